stream_minmax: RTL and testbench

- Streaming consumer of the shared unsigned `comparator` (eq/lt): tracks running minimum and maximum over a framed input stream.
- Reports min, max, their beat indices, beat count and an all-equal flag once per frame.
- Sits downstream of the comparator, instantiating it twice (candidate vs min, max vs candidate).
- Uses valid/ready on both sides.

---
 rtl/cmp_pkg.sv | 7 +
 rtl/comparator.sv | 12 +
 rtl/stream_minmax.sv | 82 ++++++++
 tb/tb_stream_minmax.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared stream_minmax state encoding and saturating-count helper
package cmp_pkg;
  typedef enum logic [1:0] {EMPTY, ACCUM, DONE} state_t;
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/comparator.sv
// comparator: unsigned compare of a against b; ports a, b in; eq (a==b), lt (a<b) out
module comparator #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt
);
  assign eq = a == b;
  assign lt = a < b;
endmodule

// File: rtl/stream_minmax.sv
// stream_minmax: per-frame running min/max with first-occurrence indices, saturating count, all-equal flag; valid/ready in (in_*) and out (out_*)
module stream_minmax
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_all_eq
);
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));
  state_t state, state_n;
  logic [WIDTH-1:0] min_r, max_r;
  logic [CNT_W-1:0] min_idx_r, max_idx_r, cnt_r;
  logic ovf_r, eq_r, acc, sat, lt_min, eq_min, lt_max, eq_max;
  comparator #(.WIDTH(WIDTH)) u_cmp_min (.a(in_data), .b(min_r), .eq(eq_min), .lt(lt_min));
  comparator #(.WIDTH(WIDTH)) u_cmp_max (.a(max_r), .b(in_data), .eq(eq_max), .lt(lt_max));
  assign acc = in_valid && in_ready;
  assign sat = cnt_r == CMAX;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == DONE) state_n = out_ready ? EMPTY : DONE;
    else if (acc) state_n = in_last ? DONE : ACCUM;
  end
  always_comb begin
    in_ready  = state != DONE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      min_r     <= '0;
      max_r     <= '0;
      min_idx_r <= '0;
      max_idx_r <= '0;
      cnt_r     <= '0;
      ovf_r     <= 1'b0;
      eq_r      <= 1'b0;
    end else if (acc && state == EMPTY) begin
      min_r     <= in_data;
      max_r     <= in_data;
      min_idx_r <= '0;
      max_idx_r <= '0;
      cnt_r     <= CNT_W'(1);
      ovf_r     <= 1'b0;
      eq_r      <= 1'b1;
    end else if (acc) begin
      if (lt_min) begin
        min_r     <= in_data;
        min_idx_r <= cnt_r;
      end
      if (lt_max) begin
        max_r     <= in_data;
        max_idx_r <= cnt_r;
      end
      cnt_r <= sat ? cnt_r : cnt_r + CNT_W'(1);
      ovf_r <= ovf_r | sat;
      eq_r  <= eq_r & eq_min & eq_max;
    end
  assign out_min     = min_r;
  assign out_max     = max_r;
  assign out_min_idx = min_idx_r;
  assign out_max_idx = max_idx_r;
  assign out_count   = cnt_r;
  assign out_ovf     = ovf_r;
  assign out_all_eq  = eq_r;
endmodule

// File: tb/tb_stream_minmax.sv
// tb_stream_minmax: directed and randomized self-checking bench for stream_minmax
module tb_stream_minmax;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid, out_ovf, out_all_eq;
  logic [7:0] out_min, out_max, out_min_idx, out_max_idx, out_count;
  logic in_ready3, out_valid3, out_ovf3, out_all_eq3;
  logic [7:0] out_min3, out_max3;
  logic [2:0] out_min_idx3, out_max_idx3, out_count3;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  stream_minmax #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min),
    .out_max(out_max), .out_min_idx(out_min_idx), .out_max_idx(out_max_idx),
    .out_count(out_count), .out_ovf(out_ovf), .out_all_eq(out_all_eq)
  );
  stream_minmax #(.WIDTH(8), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid3), .out_ready(out_ready), .out_min(out_min3),
    .out_max(out_max3), .out_min_idx(out_min_idx3), .out_max_idx(out_max_idx3),
    .out_count(out_count3), .out_ovf(out_ovf3), .out_all_eq(out_all_eq3)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic res(input string t, input logic [7:0] mn, input logic [7:0] mx,
                     input logic [7:0] mi, input logic [7:0] xi, input logic [7:0] cnt,
                     input logic ovf, input logic eq);
    chk({t, ".valid"}, 32'(out_valid), 1);
    chk({t, ".min"}, 32'(out_min), 32'(mn));
    chk({t, ".max"}, 32'(out_max), 32'(mx));
    chk({t, ".min_idx"}, 32'(out_min_idx), 32'(mi));
    chk({t, ".max_idx"}, 32'(out_max_idx), 32'(xi));
    chk({t, ".count"}, 32'(out_count), 32'(cnt));
    chk({t, ".ovf"}, 32'(out_ovf), 32'(ovf));
    chk({t, ".all_eq"}, 32'(out_all_eq), 32'(eq));
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 32'(n < 50), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  initial begin
    logic [7:0] arr [12];
    logic [7:0] mn, mx, mi, xi;
    int len, k;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.in_ready", 32'(in_ready), 1);
    chk("reset.out_valid", 32'(out_valid), 0);
    chk("reset.count", 32'(out_count), 0);
    chk("reset.min", 32'(out_min), 0);
    send(8'd5, 0); send(8'd3, 0); send(8'd9, 0); send(8'd3, 0); send(8'd1, 1);
    res("f1", 8'd1, 8'd9, 8'd4, 8'd2, 8'd5, 0, 0);
    @(negedge clk);
    chk("f1.valid_drop", 32'(out_valid), 0);
    chk("f1.ready_back", 32'(in_ready), 1);
    send(8'hA7, 1);
    chk("single.in_ready_low", 32'(in_ready), 0);
    res("single", 8'hA7, 8'hA7, 8'd0, 8'd0, 8'd1, 0, 1);
    @(negedge clk);
    chk("single.in_ready_back", 32'(in_ready), 1);
    send(8'd4, 0); send(8'd4, 0); send(8'd4, 0); send(8'd4, 1);
    res("ties", 8'd4, 8'd4, 8'd0, 8'd0, 8'd4, 0, 1);
    @(negedge clk);
    send(8'hFF, 0); send(8'h00, 0); send(8'hFF, 0); send(8'h00, 1);
    res("alt", 8'h00, 8'hFF, 8'd1, 8'd0, 8'd4, 0, 0);
    @(negedge clk);
    out_ready = 1'b0;
    send(8'd7, 0); send(8'd2, 1);
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    repeat (6) begin
      chk("hold.valid", 32'(out_valid), 1);
      chk("hold.in_ready", 32'(in_ready), 0);
      chk("hold.min", 32'(out_min), 2);
      chk("hold.max", 32'(out_max), 7);
      chk("hold.count", 32'(out_count), 2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold.release_valid", 32'(out_valid), 0);
    chk("hold.release_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    res("hold.next", 8'h55, 8'h55, 8'd0, 8'd0, 8'd1, 0, 1);
    @(negedge clk);
    for (int i = 9; i >= 0; i--) send(8'(i), i == 0);
    chk("sat3.valid", 32'(out_valid3), 1);
    chk("sat3.count", 32'(out_count3), 7);
    chk("sat3.ovf", 32'(out_ovf3), 1);
    chk("sat3.max", 32'(out_max3), 9);
    chk("sat3.max_idx", 32'(out_max_idx3), 0);
    chk("sat3.min", 32'(out_min3), 0);
    chk("sat3.min_idx", 32'(out_min_idx3), 7);
    chk("sat3.all_eq", 32'(out_all_eq3), 0);
    res("sat8", 8'd0, 8'd9, 8'd9, 8'd0, 8'd10, 0, 0);
    @(negedge clk);
    send(8'd8, 0); send(8'd2, 0);
    rst = 1'b1;
    #1 chk("rst.in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      chk("rst.no_valid", 32'(out_valid), 0);
      @(negedge clk);
    end
    send(8'd6, 1);
    res("rst.next", 8'd6, 8'd6, 8'd0, 8'd0, 8'd1, 0, 1);
    @(negedge clk);
    out_ready = 1'b0;
    for (int f = 0; f < 256; f++) begin
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) arr[i] = 8'($urandom_range(0, 15) * (f % 3 == 0 ? 1 : 17));
      mn = arr[0]; mx = arr[0]; mi = 0; xi = 0;
      for (int i = 1; i < len; i++) begin
        if (arr[i] < mn) begin mn = arr[i]; mi = 8'(i); end
        if (arr[i] > mx) begin mx = arr[i]; xi = 8'(i); end
      end
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(arr[i], i == len - 1);
      end
      res("rand", mn, mx, mi, xi, 8'(len), 0, mn == mx);
      k = int'($urandom_range(0, 3));
      repeat (k) @(negedge clk);
      chk("rand.held_valid", 32'(out_valid), 1);
      chk("rand.held_min", 32'(out_min), 32'(mn));
      out_ready = 1'b1;
      @(negedge clk);
      chk("rand.consumed", 32'(out_valid), 0);
      out_ready = 1'b0;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
